router_ctrl: RTL

ROUTER_CTRL -- requirements
Module: router_ctrl

---
 rtl/router_pkg.sv | 30 +++
 rtl/router_sreset_timer.sv | 52 +++++
 rtl/router_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the packet router controller
//
// Purpose: FSM state encoding, port count, reserved address and soft-reset
//          timeout shared by router_ctrl and router_sreset_timer.
// Ports:   none (package).

package router_pkg;

  localparam int         NUM_PORTS         = 3;
  localparam logic [1:0] ADDR_INVALID      = 2'b11;
  localparam int         SOFT_RESET_CYCLES = 30;
  localparam int         SRST_CNT_W        = $clog2(SOFT_RESET_CYCLES);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_EMPTY   = 3'd1,
    LOAD_HDR     = 3'd2,
    LOAD_DATA    = 3'd3,
    DRAIN        = 3'd4,
    CHECK_PARITY = 3'd5
  } state_t;

  // One-hot select for a destination; the reserved address maps to no port.
  function automatic logic [NUM_PORTS-1:0] port_sel(input logic [1:0] dest);
    logic [NUM_PORTS-1:0] one;
    one = {{(NUM_PORTS-1){1'b0}}, 1'b1};
    port_sel = (dest == ADDR_INVALID) ? '0 : (one << dest);
  endfunction

endpackage

// File: rtl/router_sreset_timer.sv
// rtl/router_sreset_timer.sv - per-port stale-data timer that pulses a FIFO flush
//
// Purpose: counts consecutive cycles in which the port holds data that nobody
//          reads; after SOFT_RESET_CYCLES such cycles it pulses soft_reset_o for
//          one cycle (registered) and starts counting afresh.
// Ports:   clock, resetn     - clock, synchronous active-low reset
//          fifo_empty_i      - this port's FIFO is empty
//          read_enb_i        - this port's destination read strobe
//          soft_reset_o      - one-cycle flush pulse

module router_sreset_timer
  import router_pkg::*;
(
  input  logic clock,
  input  logic resetn,
  input  logic fifo_empty_i,
  input  logic read_enb_i,
  output logic soft_reset_o
);

  logic [SRST_CNT_W-1:0] cnt_q, cnt_d;
  logic                  pulse_q, pulse_d;
  logic                  counting;

  always_comb begin
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    counting = !fifo_empty_i && !read_enb_i;
    if (!counting) begin
      cnt_d = '0;
    end else if (cnt_q == SRST_CNT_W'(SOFT_RESET_CYCLES - 1)) begin
      // This is the last counted cycle: flush next cycle, restart the count.
      cnt_d   = '0;
      pulse_d = 1'b1;
    end else begin
      cnt_d = cnt_q + SRST_CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign soft_reset_o = pulse_q;

endmodule

// File: rtl/router_ctrl.sv
// rtl/router_ctrl.sv - packet router controller: header decode, FIFO writes, parity check
//
// Purpose: accepts a byte stream (header, payload, parity), steers it into one
//          of three destination FIFOs through a one-byte hold register, checks
//          the XOR parity and flushes ports whose data goes unread.
// Ports:   clock, resetn           - clock, synchronous active-low reset
//          pkt_valid, data_in      - source byte stream (taken when !busy)
//          fifo_full, fifo_empty   - per-port FIFO status
//          read_enb                - per-port destination read strobe
//          write_enb, fifo_data    - per-port FIFO write and the byte written
//          lfd_state               - marks the cycle before the header write
//          busy                    - source stall
//          err                     - one-cycle parity error pulse
//          vld_out                 - per-port data available
//          soft_reset              - per-port FIFO flush pulse

module router_ctrl
  import router_pkg::*;
(
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [7:0]           data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] read_enb,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic [7:0]           fifo_data,
  output logic                 lfd_state,
  output logic                 busy,
  output logic                 err,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] soft_reset
);

  state_t     state_q, state_d;
  logic [1:0] dest_q, dest_d;
  logic [5:0] remain_q, remain_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_vld_q, hold_vld_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] rx_par_q, rx_par_d;
  logic       err_q, err_d;

  logic                 accept;
  logic                 wr;
  logic [NUM_PORTS-1:0] dest_sel;
  logic                 dest_full;
  logic                 dest_empty;
  logic                 dest_srst;
  logic                 hdr_empty;

  assign dest_sel   = port_sel(dest_q);
  assign dest_full  = |(fifo_full & dest_sel);
  assign dest_empty = |(fifo_empty & dest_sel);
  assign dest_srst  = |(soft_reset & dest_sel);
  assign hdr_empty  = |(fifo_empty & port_sel(data_in[1:0]));

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timer
    router_sreset_timer u_timer (
      .clock        (clock),
      .resetn       (resetn),
      .fifo_empty_i (fifo_empty[i]),
      .read_enb_i   (read_enb[i]),
      .soft_reset_o (soft_reset[i])
    );
  end

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    remain_d   = remain_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    acc_d      = acc_q;
    rx_par_d   = rx_par_q;
    err_d      = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    wr         = 1'b0;
    write_enb  = '0;

    case (state_q)
      IDLE: begin
        accept = pkt_valid;
        // Headers to the reserved address are swallowed without a trace.
        if (accept && (data_in[1:0] != ADDR_INVALID)) begin
          dest_d     = data_in[1:0];
          remain_d   = data_in[7:2];
          hold_d     = data_in;
          hold_vld_d = 1'b1;
          acc_d      = data_in;
          state_d    = hdr_empty ? LOAD_HDR : WAIT_EMPTY;
        end
      end

      WAIT_EMPTY: begin
        busy = 1'b1;
        if (dest_empty) begin
          state_d = LOAD_HDR;
        end
      end

      LOAD_HDR: begin
        busy    = 1'b1;
        state_d = LOAD_DATA;
      end

      LOAD_DATA: begin
        wr     = hold_vld_q && !dest_full;
        busy   = hold_vld_q && dest_full;
        accept = pkt_valid && !busy;
        if (wr) begin
          hold_vld_d = 1'b0;
        end
        // Accept overrides the drain above, so a write+accept in the same
        // cycle simply swaps in the new byte.
        if (accept) begin
          hold_d     = data_in;
          hold_vld_d = 1'b1;
          if (remain_q == '0) begin
            rx_par_d = data_in;
            state_d  = DRAIN;
          end else begin
            acc_d    = acc_q ^ data_in;
            remain_d = remain_q - 6'd1;
          end
        end
      end

      DRAIN: begin
        busy = 1'b1;
        wr   = hold_vld_q && !dest_full;
        if (wr) begin
          hold_vld_d = 1'b0;
          // Registered so the pulse lines up with the CHECK_PARITY cycle.
          err_d      = (acc_q != rx_par_q);
          state_d    = CHECK_PARITY;
        end
      end

      CHECK_PARITY: begin
        busy    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (wr) begin
      write_enb = dest_sel;
    end

    // A flush of our destination invalidates whatever is in flight.
    if ((state_q != IDLE) && dest_srst) begin
      state_d    = IDLE;
      hold_vld_d = 1'b0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      dest_q     <= '0;
      remain_q   <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      acc_q      <= '0;
      rx_par_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      remain_q   <= remain_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      acc_q      <= acc_d;
      rx_par_q   <= rx_par_d;
      err_q      <= err_d;
    end
  end

  assign fifo_data = hold_q;
  assign lfd_state = (state_q == LOAD_HDR);
  assign err       = err_q;
  assign vld_out   = ~fifo_empty;

endmodule
